// File: rtl/vga_pkg.sv
// Shared constants and FSM encoding for the VGA pixel-plot arbiter.
// Coordinate widths match the vga_adapter's 160x120 frame.
package vga_pkg;

    localparam int XMAX_DEF = 159;
    localparam int YMAX_DEF = 119;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int IW = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid index at or after i_ptr.
module rr_pick
    import vga_pkg::*;
#(
    parameter int NREQ = 3
)
(
    input  logic [NREQ-1:0] i_valid,
    input  logic [IW-1:0]   i_ptr,
    output logic [IW-1:0]   o_idx,
    output logic            o_found
);

    logic [IW-1:0] w_j;

    // Walk the search order backwards so the nearest candidate wins last.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_j     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = IW'((int'(i_ptr) + k) % NREQ);
            if (i_valid[w_j]) begin
                o_idx   = w_j;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Locks one pixel requester per primitive and forwards its pixels to the vga_adapter.
// Define VGA_ARB_CLIP_EN to drop and count pixels outside 0..XMAX / 0..YMAX.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XMAX = XMAX_DEF,
    parameter int YMAX = YMAX_DEF
)
(
    input  logic               CLOCK_50,
    input  logic               Reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_last,
    input  logic [XW*NREQ-1:0] req_x,
    input  logic [YW*NREQ-1:0] req_y,
    input  logic [CW*NREQ-1:0] req_colour,
    output logic [NREQ-1:0]    req_ready,
    output logic [XW-1:0]      vga_x,
    output logic [YW-1:0]      vga_y,
    output logic [CW-1:0]      vga_colour,
    output logic               vga_plot,
    output logic [IW-1:0]      owner,
    output logic               busy,
    output logic [7:0]         clip_count
);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_owner;

    logic [IW-1:0] w_win;
    logic          w_found;

    logic          w_valid;
    logic          w_last;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [CW-1:0] w_c;
    logic          w_acc;
    logic          w_clip;

    logic [XW-1:0] r_vga_x;
    logic [YW-1:0] r_vga_y;
    logic [CW-1:0] r_vga_c;
    logic          r_vga_plot;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_win),
        .o_found (w_found)
    );

    // Only the grant holder's request lines are ever looked at.
    always_comb begin
        w_valid = 1'b0;
        w_last  = 1'b0;
        w_x     = '0;
        w_y     = '0;
        w_c     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_valid = req_valid[i];
                w_last  = req_last[i];
                w_x     = req_x[XW*i +: XW];
                w_y     = req_y[YW*i +: YW];
                w_c     = req_colour[CW*i +: CW];
            end
        end
    end

    assign w_acc = (r_state == LOCKED) && w_valid;

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_found)         w_next = LOCKED;
            LOCKED:  if (w_acc && w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (r_state == LOCKED);
        if (r_state == LOCKED) begin
            req_ready[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_owner <= w_win;
            end
            if (w_acc && w_last) begin
                r_rr_ptr <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            r_vga_x    <= '0;
            r_vga_y    <= '0;
            r_vga_c    <= '0;
            r_vga_plot <= 1'b0;
        end else begin
            r_vga_plot <= w_acc && !w_clip;
            if (w_acc) begin
                r_vga_x <= w_x;
                r_vga_y <= w_y;
                r_vga_c <= w_c;
            end
        end
    end

`ifdef VGA_ARB_CLIP_EN
    localparam logic [XW-1:0] XLIM = XW'(XMAX);
    localparam logic [YW-1:0] YLIM = YW'(YMAX);

    logic [7:0] r_clip_cnt;

    assign w_clip = (w_x > XLIM) || (w_y > YLIM);

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            r_clip_cnt <= '0;
        end else if (w_acc && w_clip && r_clip_cnt != 8'hFF) begin
            r_clip_cnt <= r_clip_cnt + 8'd1;
        end
    end

    assign clip_count = r_clip_cnt;
`else
    assign w_clip     = 1'b0;
    assign clip_count = 8'd0;
`endif

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_c;
    assign vga_plot   = r_vga_plot;
    assign owner      = r_owner;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_vga_plot_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        Reset    = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_last  = '0;
    logic [23:0] req_x     = '0;
    logic [20:0] req_y     = '0;
    logic [8:0]  req_colour = '0;
    logic [2:0]  req_ready;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  clip_count;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef VGA_ARB_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    vga_plot_arbiter dut (
        .CLOCK_50   (CLOCK_50),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_ready  (req_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .owner      (owner),
        .busy       (busy),
        .clip_count (clip_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_px(input int i, input logic [7:0] x,
                          input logic [6:0] y, input logic [2:0] c,
                          input logic l);
        req_x[8*i +: 8]      = x;
        req_y[7*i +: 7]      = y;
        req_colour[3*i +: 3] = c;
        req_last[i]          = l;
    endtask

    task automatic do_reset;
        req_valid = '0;
        req_last  = '0;
        @(negedge CLOCK_50);
        Reset = 1'b0;
        @(negedge CLOCK_50);
        Reset = 1'b1;
    endtask

    function automatic bit out_of_range(input logic [7:0] x, input logic [6:0] y);
        return (int'(x) > 159) || (int'(y) > 119);
    endfunction

    task automatic test_reset;
        #3 Reset = 1'b0;
        #2;
        n_chk++;
        if ({owner, busy, vga_plot, req_ready} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: owner=%0d busy=%0b plot=%0b ready=%b, want all 0",
                     owner, busy, vga_plot, req_ready);
        end
        n_chk++;
        if ({vga_x, vga_y, vga_colour, clip_count} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_data: x=%0d y=%0d c=%0d clip=%0d, want all 0",
                     vga_x, vga_y, vga_colour, clip_count);
        end
        @(negedge CLOCK_50);
        Reset = 1'b1;
    endtask

    task automatic test_single_owner;
        do_reset();
        req_valid = 3'b001;
        set_px(0, 8'd10, 7'd20, 3'd1, 1'b0);
        tick();
        n_chk++;
        if (busy !== 1'b1 || owner !== 2'd0 || req_ready !== 3'b001 || vga_plot !== 1'b0) begin
            n_fail++;
            $display("FAIL grant0: busy=%0b owner=%0d ready=%b plot=%0b, want 1 0 001 0",
                     busy, owner, req_ready, vga_plot);
        end
        for (int k = 0; k < 3; k++) begin
            set_px(0, 8'(10 + k), 7'd20, 3'(k + 1), k == 2);
            tick();
            n_chk++;
            if (vga_plot !== 1'b1 || vga_x !== 8'(10 + k) || vga_y !== 7'd20
                || vga_colour !== 3'(k + 1)) begin
                n_fail++;
                $display("FAIL stream_px%0d: plot=%0b (%0d,%0d,c%0d), want 1 (%0d,20,c%0d)",
                         k, vga_plot, vga_x, vga_y, vga_colour, 10 + k, k + 1);
            end
        end
        req_valid = '0;
        n_chk++;
        if (busy !== 1'b0 || req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL stream_end: busy=%0b ready=%b, want 0 000", busy, req_ready);
        end
        tick();
        n_chk++;
        if (vga_plot !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_idle_plot: plot=%0b, want 0", vga_plot);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) set_px(i, 8'(30 + i), 7'(40 + i), 3'(i + 2), 1'b1);
        for (int c = 1; c <= 12; c++) begin
            tick();
            // one arbitration cycle then one pixel cycle per primitive
            n_chk++;
            if (vga_plot !== ((c % 2) == 0)) begin
                n_fail++;
                $display("FAIL b2b_plot c%0d: plot=%0b, want %0b", c, vga_plot, (c % 2) == 0);
            end
            if (c % 2 == 1) begin
                n_chk++;
                if (owner !== 2'(((c - 1) / 2) % 3) || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_owner c%0d: owner=%0d busy=%0b, want %0d 1",
                             c, owner, busy, ((c - 1) / 2) % 3);
                end
            end else begin
                n_chk++;
                if (vga_x !== 8'(30 + (c / 2 - 1) % 3) || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_x c%0d: x=%0d busy=%0b, want %0d 0",
                             c, vga_x, busy, 30 + (c / 2 - 1) % 3);
                end
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_bubble;
        do_reset();
        req_valid = 3'b010;
        set_px(1, 8'd50, 7'd60, 3'd3, 1'b0);
        tick();
        req_valid = 3'b110;
        set_px(2, 8'd70, 7'd80, 3'd4, 1'b1);
        tick();
        n_chk++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd50 || owner !== 2'd1) begin
            n_fail++;
            $display("FAIL bubble_first: plot=%0b x=%0d owner=%0d, want 1 50 1",
                     vga_plot, vga_x, owner);
        end
        req_valid = 3'b100;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_chk++;
            if (vga_plot !== 1'b0 || owner !== 2'd1 || busy !== 1'b1 || req_ready !== 3'b010) begin
                n_fail++;
                $display("FAIL bubble_%0d: plot=%0b owner=%0d busy=%0b ready=%b, want 0 1 1 010",
                         k, vga_plot, owner, busy, req_ready);
            end
        end
        req_valid = 3'b110;
        set_px(1, 8'd51, 7'd61, 3'd5, 1'b1);
        tick();
        n_chk++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd51 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_last: plot=%0b x=%0d busy=%0b, want 1 51 0",
                     vga_plot, vga_x, busy);
        end
        req_valid = 3'b100;
        tick();
        n_chk++;
        if (owner !== 2'd2 || req_ready !== 3'b100) begin
            n_fail++;
            $display("FAIL bubble_next: owner=%0d ready=%b, want 2 100", owner, req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_clip;
        logic [7:0] xs [3];
        logic [6:0] ys [3];
        int         nclip;
        xs[0] = 8'd160; ys[0] = 7'd10;
        xs[1] = 8'd5;   ys[1] = 7'd120;
        xs[2] = 8'd159; ys[2] = 7'd119;
        nclip = 0;
        do_reset();
        req_valid = 3'b001;
        set_px(0, xs[0], ys[0], 3'd7, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            bit drop;
            set_px(0, xs[k], ys[k], 3'd7, k == 2);
            tick();
            drop = CLIP && out_of_range(xs[k], ys[k]);
            if (drop) nclip++;
            n_chk++;
            if (vga_plot !== !drop || (!drop && (vga_x !== xs[k] || vga_y !== ys[k]))) begin
                n_fail++;
                $display("FAIL clip_px%0d: plot=%0b (%0d,%0d), want %0b (%0d,%0d)",
                         k, vga_plot, vga_x, vga_y, !drop, xs[k], ys[k]);
            end
        end
        req_valid = '0;
        tick();
        n_chk++;
        if (clip_count !== 8'(nclip) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clip_count: count=%0d busy=%0b, want %0d 0", clip_count, busy, nclip);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req_valid = 3'b100;
        set_px(2, 8'd90, 7'd91, 3'd6, 1'b0);
        tick();
        tick();
        n_chk++;
        if (owner !== 2'd2 || busy !== 1'b1 || vga_plot !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: owner=%0d busy=%0b plot=%0b, want 2 1 1",
                     owner, busy, vga_plot);
        end
        Reset = 1'b0;
        #2;
        n_chk++;
        if ({owner, busy, vga_plot, req_ready, vga_x, vga_y, vga_colour, clip_count} !== 33'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: owner=%0d busy=%0b plot=%0b ready=%b x=%0d y=%0d, want all 0",
                     owner, busy, vga_plot, req_ready, vga_x, vga_y);
        end
        req_valid = 3'b110;
        set_px(1, 8'd1, 7'd2, 3'd3, 1'b0);
        @(negedge CLOCK_50);
        Reset = 1'b1;
        tick();
        n_chk++;
        if (owner !== 2'd1 || req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL rstmid_restart: owner=%0d ready=%b, want 1 010", owner, req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random;
        logic [7:0] px [3];
        logic [6:0] py [3];
        logic [2:0] pc [3];
        int         rem [3];
        bit         m_locked;
        int         m_own, m_ptr, m_clip;
        do_reset();
        m_locked = 0; m_own = 0; m_ptr = 0; m_clip = 0;
        for (int i = 0; i < 3; i++) begin
            px[i]  = 8'($urandom_range(0, 170));
            py[i]  = 7'($urandom_range(0, 127));
            pc[i]  = 3'($urandom_range(0, 7));
            rem[i] = $urandom_range(1, 4);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit         exp_plot;
            int         acc;
            logic [7:0] ex;
            logic [6:0] ey;
            logic [2:0] ec;
            for (int i = 0; i < 3; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 7);
                set_px(i, px[i], py[i], pc[i], rem[i] == 1);
            end
            exp_plot = 0; acc = -1; ex = '0; ey = '0; ec = '0;
            if (!m_locked) begin
                for (int k = 2; k >= 0; k--) begin
                    if (req_valid[(m_ptr + k) % 3]) begin
                        m_own    = (m_ptr + k) % 3;
                        m_locked = 1;
                    end
                end
            end else if (req_valid[m_own]) begin
                acc = m_own;
                ex = px[m_own]; ey = py[m_own]; ec = pc[m_own];
                exp_plot = !(CLIP && out_of_range(ex, ey));
                if (!exp_plot && m_clip < 255) m_clip++;
                if (rem[m_own] == 1) begin
                    m_locked = 0;
                    m_ptr    = (m_own + 1) % 3;
                end
            end
            tick();
            n_chk++;
            if (vga_plot !== exp_plot || busy !== m_locked || owner !== 2'(m_own)
                || req_ready !== (m_locked ? 3'(1 << m_own) : 3'b000)) begin
                n_fail++;
                $display("FAIL rand_ctrl c%0d: plot=%0b busy=%0b owner=%0d ready=%b, want %0b %0b %0d",
                         cyc, vga_plot, busy, owner, req_ready, exp_plot, m_locked, m_own);
            end
            if (exp_plot) begin
                n_chk++;
                if (vga_x !== ex || vga_y !== ey || vga_colour !== ec) begin
                    n_fail++;
                    $display("FAIL rand_px c%0d: (%0d,%0d,c%0d), want (%0d,%0d,c%0d)",
                             cyc, vga_x, vga_y, vga_colour, ex, ey, ec);
                end
            end
            n_chk++;
            if (clip_count !== 8'(m_clip)) begin
                n_fail++;
                $display("FAIL rand_clip c%0d: count=%0d, want %0d", cyc, clip_count, m_clip);
            end
            if (acc >= 0) begin
                px[acc] = 8'($urandom_range(0, 170));
                py[acc] = 7'($urandom_range(0, 127));
                pc[acc] = 3'($urandom_range(0, 7));
                rem[acc] = (rem[acc] == 1) ? $urandom_range(1, 4) : rem[acc] - 1;
            end
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_owner();
        test_back_to_back();
        test_bubble();
        test_clip();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of pixel requesters (0 = clear engine, 1..NREQ-1 = circle drawers).
REQ-002 The block SHALL have parameter XMAX, default 159, giving the largest legal x coordinate.
REQ-003 The block SHALL have parameter YMAX, default 119, giving the largest legal y coordinate.
REQ-004 The block SHALL have port CLOCK_50, input, 1 bit: the clock.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, NREQ bits: per-requester pixel valid.
REQ-007 The block SHALL have port req_last, input, NREQ bits: marks the final pixel of a primitive.
REQ-008 The block SHALL have port req_x, input, 8*NREQ bits: packed x coordinates; slice i is [8i+7:8i].
REQ-009 The block SHALL have port req_y, input, 7*NREQ bits: packed y coordinates.
REQ-010 The block SHALL have port req_colour, input, 3*NREQ bits: packed colours.
REQ-011 The block SHALL have port req_ready, output, NREQ bits: per-requester pixel accept.
REQ-012 The block SHALL have ports vga_x (output, 8 bits), vga_y (output, 7 bits), vga_colour (output, 3 bits) and vga_plot (output, 1 bit), which drive the vga_adapter.
REQ-013 The block SHALL have port owner, output, 2 bits: index of the current grant holder.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a primitive is locked.
REQ-015 The block SHALL have port clip_count, output, 8 bits: count of dropped out-of-range pixels.

Function
REQ-016 The block SHALL implement a two-state FSM with states IDLE and LOCKED.
REQ-017 In IDLE, if any req_valid is high, the FSM SHALL choose a winner round-robin, starting the search at rr_ptr, register it into owner, and enter LOCKED on the next edge; otherwise it SHALL stay in IDLE.
REQ-018 req_ready[i] SHALL be high only when state is LOCKED and owner equals i; it SHALL be low in IDLE.
REQ-019 A pixel SHALL be accepted in any cycle where req_valid[owner] and req_ready[owner] are both high.
REQ-020 An accepted pixel SHALL appear registered on vga_x, vga_y and vga_colour with vga_plot high exactly one cycle later (latency 1).
REQ-021 vga_plot SHALL be low in every cycle that does not follow an accepted, in-range pixel.
REQ-022 While LOCKED, a low req_valid[owner] SHALL produce a bubble: no plot, and the grant is retained.
REQ-023 Other requesters SHALL never be granted mid-primitive.
REQ-024 Accepting a pixel with req_last[owner] high SHALL return the FSM to IDLE on the next edge and set rr_ptr to (owner+1) mod NREQ.
REQ-025 A single-pixel primitive (valid and last together on the first beat) SHALL be legal.
REQ-026 Each primitive SHALL cost exactly one IDLE arbitration cycle.
REQ-027 busy SHALL equal (state == LOCKED).
REQ-028 Request signals of non-owners SHALL be ignored.
REQ-029 Requesters SHALL hold x, y, colour and last stable while valid is high and ready is low.

Reset
REQ-030 While Reset is low, asynchronously: state = IDLE, rr_ptr = 0, owner = 0, vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 0, clip_count = 0, req_ready = 0.
REQ-031 Reset asserted mid-primitive SHALL abandon that primitive; after release, arbitration SHALL restart with requester 0 highest priority.

Configuration
REQ-032 With VGA_ARB_CLIP_EN defined, an accepted pixel with x > XMAX or y > YMAX SHALL still be accepted (ready/last handling unchanged) but SHALL NOT plot.
REQ-033 With VGA_ARB_CLIP_EN defined, clip_count SHALL increment for each clipped pixel and saturate at 255.
REQ-034 With VGA_ARB_CLIP_EN undefined, all accepted pixels SHALL plot unmodified (coordinates wrap as in the adapter) and clip_count SHALL be tied to 0.

Structure
REQ-035 A shared package vga_pkg SHALL hold: XMAX/YMAX defaults, the coordinate and colour widths (8/7/3), and the FSM state enumeration.
REQ-036 One sub-module, rr_pick, SHALL be used: a combinational round-robin selector taking the valid vector and rr_ptr and returning the winner index and a found flag.

Verification
REQ-037 A bench SHALL apply: reset, then req_valid = 3'b001 with last on the 3rd pixel (10,20), (11,20), (12,20) -> owner 0, vga_plot high for 3 cycles with those coordinates, then busy low.
REQ-038 A bench SHALL apply: req_valid = 3'b111 held continuously, single-pixel primitives -> grant order 0,1,2,0,1,2; one plot every 2 cycles.
REQ-039 A bench SHALL apply: owner 1 drops valid for 5 cycles mid-primitive while requester 2 is valid -> 5 bubble cycles, owner stays 1, and requester 2 is not granted until requester 1's last beat is accepted.
REQ-040 A bench SHALL apply, with VGA_ARB_CLIP_EN defined: pixels (160,10), (5,120), (159,119) -> only (159,119) plots and clip_count = 2; with the macro undefined, all three plot and clip_count = 0.
REQ-041 A bench SHALL apply: Reset pulsed low while owner = 2 is LOCKED -> all outputs 0 immediately; after release with 3'b110 valid -> requester 1 wins first.
